regfile_writeback: RTL and testbench

Write-port front end for the 32-entry general-purpose register file. Merges single-cycle ALU results and long-latency memory/multiply results into the file's single write port, drives its `write_enable`/`write_addr`/`write_data` inputs from registers, and keeps a pending-write scoreboard that decode uses for hazard checks. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 75 +++++++
 rtl/regfile_writeback.sv | 168 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
//   Shared definitions for the register-file write-port front end.
//   REG_ADDR_W / NUM_REGS describe the 32-entry general-purpose register file.
//   wb_src_t names the source that owns the write port in a given cycle.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Synchronous first-in first-out buffer for long-latency write-back entries.
//   Storage is a register array. The head is read straight from the array
//   entry under the read pointer, so a push only becomes visible at the head
//   after the clock edge that writes it.
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   push, push_data : write an entry (ignored while full)
//   pop             : discard the head entry (ignored while empty)
//   count           : registered occupancy, 0..DEPTH
//   head            : oldest stored entry
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // tells full from empty when the pointers are equal.
    always_comb begin
        push_ok  = push && (count_q != CNT_DEPTH);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: an entry is only observed after a push.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-port front end for the 32-entry register file. Single-cycle ALU
//   results and queued long-latency results share the one write port; the
//   write_* outputs come straight from registers. A pending-write scoreboard
//   tells decode which registers still await a long-latency result.
// Handshakes
//   A transfer happens on a rising edge where valid && ready. ready depends
//   only on registered state, never on valid; upstream holds its payload
//   stable while valid is high and ready is low.
// Ports
//   clock, reset                      : rising-edge clock, async active-high reset
//   alu_valid/alu_ready/addr/data     : single-cycle result
//   mem_valid/mem_ready/addr/data     : long-latency result, pushed to a FIFO
//   mark_valid, mark_addr             : decode issued a long-latency op
//   pending                           : outstanding long-latency writes
//   queue_count                       : FIFO occupancy
//   write_enable/write_addr/write_data: register-file write port
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_ADDR_W-1:0]        alu_addr,
    input  logic [WORD_SIZE-1:0]         alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_ADDR_W-1:0]        mem_addr,
    input  logic [WORD_SIZE-1:0]         mem_data,
    input  logic                         mark_valid,
    input  logic [REG_ADDR_W-1:0]        mark_addr,
    output logic [NUM_REGS-1:0]          pending,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         write_enable,
    output logic [REG_ADDR_W-1:0]        write_addr,
    output logic [WORD_SIZE-1:0]         write_data
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = REG_ADDR_W + WORD_SIZE;
    localparam int SC_W    = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(QUEUE_DEPTH);
    localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);

    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [WORD_SIZE-1:0]  head_data;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    wb_src_t               wb_src;

    logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  write_enable_q, write_enable_d;
    logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [WORD_SIZE-1:0]  write_data_q, write_data_d;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({mem_addr, mem_data}),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Arbitration. Once the FIFO head has lost STARVE_LIMIT cycles in a row,
    // alu_ready drops, the ALU cannot win, and the head is popped instead.
    always_comb begin
        head_addr  = fifo_head[ENTRY_W-1:WORD_SIZE];
        head_data  = fifo_head[WORD_SIZE-1:0];
        fifo_empty = (fifo_count == '0);
        alu_ready  = (starve_cnt_q != SC_LIMIT);
        // Full never accepts, even in a popping cycle; keeps ready registered-only.
        mem_ready  = (fifo_count != CNT_DEPTH);
        fifo_push  = mem_valid && mem_ready;

        if (alu_valid && alu_ready) begin
            wb_src = WB_ALU;
        end else if (!fifo_empty) begin
            wb_src = WB_MEM;
        end else begin
            wb_src = WB_NONE;
        end
        fifo_pop = (wb_src == WB_MEM);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_d = '0;
        end else if (wb_src == WB_ALU) begin
            // Cannot exceed the limit: at the limit the ALU is not ready.
            starve_cnt_d = starve_cnt_q + SC_ONE;
        end
    end

    // Scoreboard: clear on pop first so a same-cycle mark wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && (head_addr != '0)) begin
            pending_d[head_addr] = 1'b0;
        end
        if (mark_valid && (mark_addr != '0)) begin
            pending_d[mark_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Write port. Address and data follow every winner, including x0
    // entries that are consumed without asserting the enable.
    always_comb begin
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        case (wb_src)
            WB_ALU: begin
                write_enable_d = (alu_addr != '0);
                write_addr_d   = alu_addr;
                write_data_d   = alu_data;
            end
            WB_MEM: begin
                write_enable_d = (head_addr != '0);
                write_addr_d   = head_addr;
                write_data_d   = head_data;
            end
            default: begin
                write_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q   <= '0;
            pending_q      <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            pending_q      <= pending_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    assign pending      = pending_q;
    assign queue_count  = fifo_count;
    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int WS     = 32;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 3;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        alu_valid = 0, mem_valid = 0, mark_valid = 0;
    logic [4:0]  alu_addr = 0, mem_addr = 0, mark_addr = 0;
    logic [31:0] alu_data = 0, mem_data = 0;
    logic        alu_ready, mem_ready, write_enable;
    logic [31:0] pending;
    logic [2:0]  queue_count;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    regfile_writeback #(
        .WORD_SIZE    (WS),
        .QUEUE_DEPTH  (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mark_valid   (mark_valid),
        .mark_addr    (mark_addr),
        .pending      (pending),
        .queue_count  (queue_count),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of {addr, data}, a pending bit per register, and a count of
    // consecutive cycles the queued head has been passed over.
    logic [36:0] exp_q[$];
    logic [31:0] pend_m;
    int          starve_m;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic model_clear();
        exp_q.delete();
        pend_m   = '0;
        starve_m = 0;
        m_we     = 0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    // Evaluates the cycle from the driven inputs, clocks, then compares.
    task automatic step(output bit alu_acc, output bit mem_acc);
        int          sz;
        bit          pop;
        logic [36:0] h;
        sz      = exp_q.size();
        alu_acc = alu_valid && (starve_m != LIMIT);
        mem_acc = mem_valid && (sz != DEPTH);
        pop     = !alu_acc && (sz != 0);
        if (alu_acc) begin
            m_we = (alu_addr != 0);
            m_wa = alu_addr;
            m_wd = alu_data;
        end else if (pop) begin
            h    = exp_q.pop_front();
            m_we = (h[36:32] != 0);
            m_wa = h[36:32];
            m_wd = h[31:0];
            if (h[36:32] != 0) pend_m[h[36:32]] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (sz == 0 || pop) starve_m = 0;
        else if (alu_acc) starve_m = starve_m + 1;
        if (mark_valid && mark_addr != 0) pend_m[mark_addr] = 1'b1;
        if (mem_acc) exp_q.push_back({mem_addr, mem_data});
        @(posedge clock);
        #1;
        chk("m_we", {31'd0, write_enable}, {31'd0, m_we});
        chk("m_wa", {27'd0, write_addr}, {27'd0, m_wa});
        chk("m_wd", write_data, m_wd);
        chk("m_pend", pending, pend_m);
        chk("m_cnt", {29'd0, queue_count}, exp_q.size());
        chk("m_ardy", {31'd0, alu_ready}, {31'd0, (starve_m != LIMIT)});
        chk("m_mrdy", {31'd0, mem_ready}, {31'd0, (exp_q.size() != DEPTH)});
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        mark_valid = 0; mark_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        model_clear();
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic        kv; logic [4:0] ka;
        logic        ewe; logic [4:0] ewa; logic [31:0] ewd;
        logic [31:0] epend; logic [2:0] ecnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic kv, input logic [4:0] ka,
                                input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                                input logic [31:0] epend, input logic [2:0] ecnt);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.kv = kv; v.ka = ka; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
        v.epend = epend; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        bit aa_acc, mm_acc;
        bit alu_hold, mem_hold;

        // Reset values while reset is held.
        #1;
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_wa", {27'd0, write_addr}, 32'd0);
        chk("rst_wd", write_data, 32'd0);
        chk("rst_pend", pending, 32'd0);
        chk("rst_cnt", {29'd0, queue_count}, 32'd0);
        chk("rst_ardy", {31'd0, alu_ready}, 32'd1);
        chk("rst_mrdy", {31'd0, mem_ready}, 32'd1);
        do_reset();

        // Directed vectors: ALU write, scoreboard round trip, x0 drops, collision.
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 1, 5, 32'hDEADBEEF, 32'h0,   3'd0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 5, 32'hDEADBEEF, 32'h0,   3'd0);
        vecs[2]  = mk(0, 0, 0,            0, 0, 0,       1, 7, 0, 5, 32'hDEADBEEF, 32'h80,  3'd0);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 5, 32'hDEADBEEF, 32'h80,  3'd0);
        vecs[4]  = mk(0, 0, 0,            1, 7, 32'h1234, 0, 0, 0, 5, 32'hDEADBEEF, 32'h80,  3'd1);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 1, 7, 32'h1234,     32'h0,   3'd0);
        vecs[6]  = mk(1, 0, 32'h55,       0, 0, 0,       0, 0, 0, 0, 32'h55,       32'h0,   3'd0);
        vecs[7]  = mk(0, 0, 0,            1, 0, 32'h66,  0, 0, 0, 0, 32'h55,       32'h0,   3'd1);
        vecs[8]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 0, 32'h66,       32'h0,   3'd0);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,       1, 9, 0, 0, 32'h66,       32'h200, 3'd0);
        vecs[10] = mk(0, 0, 0,            1, 9, 32'hAA,  0, 0, 0, 0, 32'h66,       32'h200, 3'd1);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,       1, 9, 1, 9, 32'hAA,       32'h200, 3'd0);
        vecs[12] = mk(0, 0, 0,            1, 9, 32'hBB,  0, 0, 0, 9, 32'hAA,       32'h200, 3'd1);
        vecs[13] = mk(0, 0, 0,            0, 0, 0,       0, 0, 1, 9, 32'hBB,       32'h0,   3'd0);

        for (int i = 0; i < 14; i++) begin
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            mark_valid = vecs[i].kv; mark_addr = vecs[i].ka;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_we", i), {31'd0, write_enable}, {31'd0, vecs[i].ewe});
            chk($sformatf("v%0d_wa", i), {27'd0, write_addr}, {27'd0, vecs[i].ewa});
            chk($sformatf("v%0d_wd", i), write_data, vecs[i].ewd);
            chk($sformatf("v%0d_pend", i), pending, vecs[i].epend);
            chk($sformatf("v%0d_cnt", i), {29'd0, queue_count}, {29'd0, vecs[i].ecnt});
        end
        idle_inputs();

        // Full FIFO and starvation: ALU always valid, five queued results.
        do_reset();
        alu_valid = 1; alu_addr = 1; alu_data = 32'hA000_0001;
        mem_valid = 1; mem_addr = 10; mem_data = 32'hB000_000A;
        for (int e = 1; e <= 6; e++) begin
            step(aa_acc, mm_acc);
            if (aa_acc) begin
                alu_addr = alu_addr + 5'd1;
                alu_data = 32'hA000_0000 + {27'd0, alu_addr};
            end
            if (mm_acc) begin
                mem_addr = mem_addr + 5'd1;
                mem_data = 32'hB000_0000 + {27'd0, mem_addr};
                if (mem_addr == 5'd15) mem_valid = 0;
            end
            if (e == 4) begin
                chk("stv_ardy_low", {31'd0, alu_ready}, 32'd0);
                chk("stv_mrdy_low", {31'd0, mem_ready}, 32'd0);
                chk("stv_full", {29'd0, queue_count}, 32'd4);
            end
            if (e == 5) begin
                chk("stv_head_we", {31'd0, write_enable}, 32'd1);
                chk("stv_head_wa", {27'd0, write_addr}, 32'd10);
                chk("stv_head_wd", write_data, 32'hB000_000A);
                chk("stv_ardy_back", {31'd0, alu_ready}, 32'd1);
                chk("stv_cnt3", {29'd0, queue_count}, 32'd3);
            end
            if (e == 6) chk("stv_held_alu", {27'd0, write_addr}, 32'd5);
        end
        alu_valid = 0;
        for (int e = 0; e < 5; e++) step(aa_acc, mm_acc);
        chk("stv_drained", {29'd0, queue_count}, 32'd0);

        // Reset mid-flight with three queued entries and pending bits.
        do_reset();
        alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
        for (int e = 0; e < 3; e++) begin
            mem_valid = 1; mem_addr = 5'(11 + e); mem_data = 32'hC0 + e;
            mark_valid = 1; mark_addr = 5'(11 + e);
            step(aa_acc, mm_acc);
        end
        idle_inputs();
        chk("mid_cnt_pre", {29'd0, queue_count}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_cnt", {29'd0, queue_count}, 32'd0);
        chk("mid_pend", pending, 32'd0);
        chk("mid_we", {31'd0, write_enable}, 32'd0);
        @(negedge clock);
        model_clear();
        reset = 1'b0;
        for (int e = 0; e < 6; e++) step(aa_acc, mm_acc);

        // Randomised traffic against the model; upstream holds unaccepted payloads.
        do_reset();
        alu_hold = 0; mem_hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            if (!mem_hold) begin
                mem_valid = ($urandom_range(0, 1) != 0);
                mem_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mem_data  = $urandom;
            end
            mark_valid = ($urandom_range(0, 3) == 0);
            mark_addr  = 5'($urandom_range(0, 31));
            step(aa_acc, mm_acc);
            alu_hold = alu_valid && !aa_acc;
            mem_hold = mem_valid && !mm_acc;
        end
        idle_inputs();
        for (int e = 0; e < 6; e++) step(aa_acc, mm_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
